// File: rtl/cmos_frame_crop_if.sv
// Camera-side pixel stream and FIFO-side write port of the frame cropper.
// The cropper is the slave: it consumes camera signals and drives the FIFO.
interface cmos_frame_crop_if;
  logic        cmos_vsync;
  logic        cmos_href;
  logic        pix_valid;
  logic [15:0] pix_data;
  logic        wr_en;
  logic [15:0] wr_data;

  modport master (
    output cmos_vsync, cmos_href, pix_valid, pix_data,
    input  wr_en, wr_data
  );

  modport slave (
    input  cmos_vsync, cmos_href, pix_valid, pix_data,
    output wr_en, wr_data
  );
endinterface

// File: rtl/cmos_frame_crop.sv
// Counts camera pixels/lines per frame and forwards a cropped window
// to the SDRAM write FIFO with per-frame start/done/abort pulses.
module cmos_frame_crop #(
  parameter int IN_W    = 640,
  parameter int IN_H    = 480,
  parameter int X_START = 0,
  parameter int Y_START = 0,
  parameter int OUT_W   = 640,
  parameter int OUT_H   = 480
) (
  input  logic             cmos_pclk,
  input  logic             rst_n,
  input  logic             capture_en,
  cmos_frame_crop_if.slave cam,
  output logic             frame_start,
  output logic             frame_done,
  output logic             frame_abort,
  output logic             len_err
);

  typedef enum logic [1:0] {
    WAIT_VS = 2'd0,
    ACTIVE  = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam logic [11:0] IW = 12'(IN_W);
  localparam logic [11:0] XS = 12'(X_START);
  localparam logic [11:0] OW = 12'(OUT_W);
  localparam logic [10:0] YS = 11'(Y_START);
  localparam logic [10:0] OH = 11'(OUT_H);
  localparam logic [10:0] YE = 11'(Y_START + OUT_H);

  state_t      state, state_nx;
  logic        vsync_r, href_r, px_stb;
  logic [11:0] x_cnt, x_nx;
  logic [10:0] y_cnt, y_nx, y_inc;
  logic [12:0] x_diff;
  logic [11:0] y_diff;
  logic        vs_pos, line_end, x_ovf;
  logic        keep, line_has, last_line;
  logic        wr_en_nx, fs_nx, fd_nx, fa_nx, le_nx;
  logic [15:0] wr_data_nx;

  assign vs_pos    = cam.cmos_vsync & ~vsync_r;
  assign line_end  = href_r & ~cam.cmos_href;
  assign x_ovf     = (x_cnt == IW);
  // Borrow bit of the offset doubles as the lower-bound test.
  assign x_diff    = {1'b0, x_cnt} - {1'b0, XS};
  assign y_diff    = {1'b0, y_cnt} - {1'b0, YS};
  assign keep      = px_stb && !x_ovf
                   && !x_diff[12] && (x_diff[11:0] < OW)
                   && !y_diff[11] && (y_diff[10:0] < OH);
  // A pixel landing with the href fall still makes the line non-empty.
  assign line_has  = (x_cnt != 12'd0) | px_stb;
  assign y_inc     = y_cnt + 11'd1;
  assign last_line = (y_inc == YE);

  always_ff @(posedge cmos_pclk) begin
    if (!rst_n) state <= WAIT_VS;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      WAIT_VS, DONE: begin
        if (vs_pos && capture_en) state_nx = ACTIVE;
      end
      ACTIVE: begin
        if (vs_pos)
          state_nx = capture_en ? ACTIVE : WAIT_VS;
        else if (line_end && line_has && last_line)
          state_nx = DONE;
      end
      default: state_nx = WAIT_VS;
    endcase
  end

  always_comb begin
    wr_en_nx   = 1'b0;
    wr_data_nx = cam.wr_data;
    fs_nx      = 1'b0;
    fd_nx      = 1'b0;
    fa_nx      = 1'b0;
    le_nx      = len_err;
    x_nx       = x_cnt;
    y_nx       = y_cnt;
    unique case (state)
      WAIT_VS, DONE: begin
        if (vs_pos && capture_en) begin
          fs_nx = 1'b1;
          x_nx  = 12'd0;
          y_nx  = 11'd0;
        end
      end
      ACTIVE: begin
        if (vs_pos) begin
          fa_nx = 1'b1;
          fs_nx = capture_en;
          x_nx  = 12'd0;
          y_nx  = 11'd0;
        end else begin
          if (px_stb) begin
            if (x_ovf) le_nx = 1'b1;
            else       x_nx  = x_cnt + 12'd1;
            if (keep) begin
              wr_en_nx   = 1'b1;
              wr_data_nx = cam.pix_data;
            end
          end
          if (line_end) begin
            x_nx = 12'd0;
            if (line_has) begin
              y_nx  = y_inc;
              fd_nx = last_line;
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge cmos_pclk) begin
    if (!rst_n) begin
      vsync_r     <= 1'b0;
      href_r      <= 1'b0;
      px_stb      <= 1'b0;
      x_cnt       <= 12'd0;
      y_cnt       <= 11'd0;
      cam.wr_en   <= 1'b0;
      cam.wr_data <= 16'd0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      len_err     <= 1'b0;
    end else begin
      vsync_r     <= cam.cmos_vsync;
      href_r      <= cam.cmos_href;
      px_stb      <= cam.pix_valid;
      x_cnt       <= x_nx;
      y_cnt       <= y_nx;
      cam.wr_en   <= wr_en_nx;
      cam.wr_data <= wr_data_nx;
      frame_start <= fs_nx;
      frame_done  <= fd_nx;
      frame_abort <= fa_nx;
      len_err     <= le_nx;
    end
  end

endmodule

// File: tb/tb_cmos_frame_crop.sv
// Bench for cmos_frame_crop: a cropping instance and a full-window
// instance share one camera stream and are scored against a frame model.
module tb_cmos_frame_crop;

  localparam int IW [2] = '{16, 16};
  localparam int IH [2] = '{8, 8};
  localparam int XS [2] = '{8, 0};
  localparam int YS [2] = '{2, 0};
  localparam int OW [2] = '{4, 16};
  localparam int OH [2] = '{3, 8};

  typedef struct { logic [15:0] d; int t; } wr_t;
  typedef struct { int k; int t; } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, cap, vsync, href, pv;
  logic [15:0] pd;
  logic [1:0]  fs, fd, fa, le;
  int          cyc = 0;
  int          total = 0;
  int          passed = 0;

  always @(posedge clk) cyc <= cyc + 1;

  cmos_frame_crop_if if_a ();
  cmos_frame_crop_if if_b ();

  assign if_a.cmos_vsync = vsync;
  assign if_a.cmos_href  = href;
  assign if_a.pix_valid  = pv;
  assign if_a.pix_data   = pd;
  assign if_b.cmos_vsync = vsync;
  assign if_b.cmos_href  = href;
  assign if_b.pix_valid  = pv;
  assign if_b.pix_data   = pd;

  cmos_frame_crop #(
    .IN_W(IW[0]), .IN_H(IH[0]), .X_START(XS[0]),
    .Y_START(YS[0]), .OUT_W(OW[0]), .OUT_H(OH[0])
  ) dut_a (
    .cmos_pclk(clk), .rst_n(rst_n), .capture_en(cap), .cam(if_a),
    .frame_start(fs[0]), .frame_done(fd[0]),
    .frame_abort(fa[0]), .len_err(le[0])
  );

  cmos_frame_crop #(
    .IN_W(IW[1]), .IN_H(IH[1]), .X_START(XS[1]),
    .Y_START(YS[1]), .OUT_W(OW[1]), .OUT_H(OH[1])
  ) dut_b (
    .cmos_pclk(clk), .rst_n(rst_n), .capture_en(cap), .cam(if_b),
    .frame_start(fs[1]), .frame_done(fd[1]),
    .frame_abort(fa[1]), .len_err(le[1])
  );

  wr_t ew [2][$];
  wr_t ow [2][$];
  ev_t ee [2][$];
  ev_t oe [2][$];
  bit  m_act [2];
  int  m_y [2];
  bit  m_len [2];

  always @(negedge clk) begin
    if (if_a.wr_en === 1'b1) ow[0].push_back(wr_t'{if_a.wr_data, cyc});
    if (if_b.wr_en === 1'b1) ow[1].push_back(wr_t'{if_b.wr_data, cyc});
    for (int d = 0; d < 2; d++) begin
      if (fs[d] === 1'b1) oe[d].push_back(ev_t'{0, cyc});
      if (fd[d] === 1'b1) oe[d].push_back(ev_t'{1, cyc});
      if (fa[d] === 1'b1) oe[d].push_back(ev_t'{2, cyc});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic bit in_win(input int d, input int x, input int y);
    return x >= XS[d] && x < XS[d] + OW[d] &&
           y >= YS[d] && y < YS[d] + OH[d];
  endfunction

  task automatic do_vsync(input bit c);
    tick();
    vsync = 1'b1;
    cap   = c;
    for (int d = 0; d < 2; d++) begin
      if (c) ee[d].push_back(ev_t'{0, cyc + 1});
      if (m_act[d]) ee[d].push_back(ev_t'{2, cyc + 1});
      m_act[d] = c;
      m_y[d]   = 0;
    end
    repeat (3) tick();
    vsync = 1'b0;
    cap   = 1'($urandom);
    repeat (2) tick();
  endtask

  task automatic line_end_model(input int npix);
    for (int d = 0; d < 2; d++) begin
      if (m_act[d] && npix > 0) begin
        m_y[d]++;
        if (m_y[d] == YS[d] + OH[d]) begin
          ee[d].push_back(ev_t'{1, cyc + 1});
          m_act[d] = 1'b0;
        end
      end
    end
  endtask

  task automatic do_line(input int fid, input int y, input int npix);
    bit          co;
    logic [15:0] val;
    co = 1'($urandom);
    tick();
    href = 1'b1;
    tick();
    for (int x = 0; x < npix; x++) begin
      val = 16'(fid * 256 + y * 16 + x);
      pv  = 1'b1;
      pd  = 16'($urandom);
      cap = 1'($urandom);
      for (int d = 0; d < 2; d++) begin
        if (m_act[d]) begin
          if (x >= IW[d]) m_len[d] = 1'b1;
          else if (in_win(d, x, m_y[d]))
            ew[d].push_back(wr_t'{val, cyc + 2});
        end
      end
      tick();
      pv = 1'b0;
      pd = val;
      if (co && x == npix - 1) begin
        href = 1'b0;
        line_end_model(npix);
      end
      tick();
      pd = 16'($urandom);
      if ($urandom_range(1) == 1) tick();
    end
    if (!co || npix == 0) begin
      href = 1'b0;
      line_end_model(npix);
    end
    repeat (2) tick();
  endtask

  task automatic do_lines(input int fid, input int n, input int long_y);
    for (int y = 0; y < n; y++)
      do_line(fid, y, (y == long_y) ? 18 : 16);
  endtask

  task automatic cmp(input string tag);
    int n;
    repeat (4) tick();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_d%0d_nwr", tag, d), ow[d].size(), ew[d].size());
      n = (ow[d].size() < ew[d].size()) ? ow[d].size() : ew[d].size();
      for (int i = 0; i < n; i++) begin
        chk($sformatf("%s_d%0d_wdata%0d", tag, d, i), ow[d][i].d, ew[d][i].d);
        chk($sformatf("%s_d%0d_wcyc%0d", tag, d, i), ow[d][i].t, ew[d][i].t);
      end
      chk($sformatf("%s_d%0d_nev", tag, d), oe[d].size(), ee[d].size());
      n = (oe[d].size() < ee[d].size()) ? oe[d].size() : ee[d].size();
      for (int i = 0; i < n; i++) begin
        chk($sformatf("%s_d%0d_evkind%0d", tag, d, i), oe[d][i].k, ee[d][i].k);
        chk($sformatf("%s_d%0d_evcyc%0d", tag, d, i), oe[d][i].t, ee[d][i].t);
      end
      ow[d].delete();
      ew[d].delete();
      oe[d].delete();
      ee[d].delete();
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_a_wr_en"}, 32'(if_a.wr_en), 32'd0);
    chk({tag, "_a_wr_data"}, 32'(if_a.wr_data), 32'd0);
    chk({tag, "_b_wr_en"}, 32'(if_b.wr_en), 32'd0);
    chk({tag, "_b_wr_data"}, 32'(if_b.wr_data), 32'd0);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_d%0d_fs", tag, d), 32'(fs[d]), 32'd0);
      chk($sformatf("%s_d%0d_fd", tag, d), 32'(fd[d]), 32'd0);
      chk($sformatf("%s_d%0d_fa", tag, d), 32'(fa[d]), 32'd0);
      chk($sformatf("%s_d%0d_len", tag, d), 32'(le[d]), 32'd0);
    end
  endtask

  task automatic chk_len(input string tag);
    for (int d = 0; d < 2; d++)
      chk($sformatf("%s_d%0d_len", tag, d), 32'(le[d]), 32'(m_len[d]));
  endtask

  initial begin
    rst_n = 1'b0;
    cap   = 1'b0;
    vsync = 1'b0;
    href  = 1'b0;
    pv    = 1'b0;
    pd    = 16'd0;
    for (int d = 0; d < 2; d++) begin
      m_act[d] = 1'b0;
      m_y[d]   = 0;
      m_len[d] = 1'b0;
    end
    repeat (3) tick();
    chk_zero("reset");
    rst_n = 1'b1;
    repeat (2) tick();

    do_vsync(1'b1);
    do_lines(0, 8, -1);
    cmp("full");
    chk_len("full");

    do_vsync(1'b0);
    do_lines(1, 8, -1);
    cmp("nocap");

    do_vsync(1'b1);
    do_lines(2, 3, -1);
    do_line(2, 3, 0);
    do_vsync(1'b1);
    for (int y = 0; y < 8; y++) begin
      if (y == 4) do_line(3, 15, 0);
      do_line(3, y, 16);
    end
    cmp("abort");

    do_vsync(1'b1);
    do_lines(4, 8, 2);
    chk_len("long");
    do_vsync(1'b1);
    do_lines(5, 8, -1);
    cmp("long");
    chk_len("sticky");

    do_vsync(1'b1);
    do_lines(6, 2, -1);
    do_vsync(1'b0);
    do_lines(6, 8, -1);
    cmp("abort_off");

    do_vsync(1'b1);
    do_lines(7, 2, -1);
    tick();
    href = 1'b1;
    tick();
    pv = 1'b1;
    pd = 16'($urandom);
    tick();
    pv    = 1'b0;
    pd    = 16'h1234;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int d = 0; d < 2; d++) begin
      m_act[d] = 1'b0;
      m_len[d] = 1'b0;
    end
    chk_zero("midrst");
    repeat (3) tick();
    href = 1'b0;
    repeat (2) tick();
    do_lines(7, 8, -1);
    cmp("midrst");

    do_vsync(1'b1);
    do_lines(8, 8, -1);
    cmp("after_rst");
    chk_len("after_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cmos_frame_crop.md
Name: cmos_frame_crop

Overview:
- Sits directly downstream of the OV5640 byte-to-RGB565 assembler, in the cmos_pclk domain.
- Counts pixels and lines of each camera frame and crops a programmable window.
- Emits a write strobe and pixel word to the SDRAM write FIFO.
- Emits frame start/done/abort pulses so the SDRAM controller can rewind its write address per frame.

Parameters:
- IN_W, 640, active pixels per camera line.
- IN_H, 480, active lines per camera frame.
- X_START, 0, first kept pixel column. Constraint: X_START+OUT_W <= IN_W.
- Y_START, 0, first kept line. Constraint: Y_START+OUT_H <= IN_H.
- OUT_W, 640, kept pixels per line.
- OUT_H, 480, kept lines per frame.

Ports:
- cmos_pclk  input  1  pixel clock; the only clock.
- rst_n  input  1  synchronous active-low reset.
- cmos_vsync  input  1  camera frame sync; rising edge marks frame start.
- cmos_href  input  1  camera line valid.
- capture_en  input  1  enable; sampled only on a vsync rising edge.
- pix_valid  input  1  upstream pixel ready pulse, one cycle per pixel.
- pix_data  input  16  upstream RGB565; complete one cycle after pix_valid.
- wr_en  output  1  FIFO write strobe.
- wr_data  output  16  pixel word to FIFO.
- frame_start  output  1  one-cycle pulse when a capture begins.
- frame_done  output  1  one-cycle pulse after the last kept pixel of a frame.
- frame_abort  output  1  one-cycle pulse when a vsync edge arrives before the frame completes.
- len_err  output  1  sticky; set when a line carries more than IN_W pixels.

Behaviour:
- Clock and reset: single clock cmos_pclk. rst_n is synchronous, active-low.
- Reset values: wr_en=0, wr_data=0, frame_start=0, frame_done=0, frame_abort=0, len_err=0. Counters x_cnt (12b) and y_cnt (11b) = 0. All edge-detect registers = 0. State = WAIT_VS.
- Edge detection, all registered:
  - vs_pos = cmos_vsync & ~vsync_r.
  - line_end = href_r & ~cmos_href.
  - px_stb = pix_valid delayed one cycle. pix_data is sampled only when px_stb=1, because the upstream word is complete only then.
- WAIT_VS:
  - vs_pos with capture_en=1: go to ACTIVE, pulse frame_start next cycle, clear x_cnt and y_cnt.
  - vs_pos with capture_en=0: stay in WAIT_VS.
- ACTIVE, on px_stb:
  - Keep the pixel if X_START <= x_cnt < X_START+OUT_W and Y_START <= y_cnt < Y_START+OUT_H.
  - A kept pixel registers wr_en=1 and wr_data=pix_data; both are visible the cycle after px_stb (total latency 2 cycles from pix_valid).
  - x_cnt increments while x_cnt < IN_W.
  - If x_cnt == IN_W: set len_err, hold x_cnt, do not write.
- ACTIVE, on line_end:
  - x_cnt clears to 0.
  - y_cnt increments only if x_cnt != 0 (empty href pulses are ignored).
  - If the incremented y_cnt == Y_START+OUT_H: pulse frame_done next cycle and go to DONE.
- DONE:
  - No writes.
  - vs_pos: same handling as in WAIT_VS, so continuous capture works when capture_en stays high.
- Same-cycle px_stb and line_end: the pixel is evaluated with the pre-clear x_cnt/y_cnt, then the line_end update applies. No pixel is lost.
- vs_pos while in ACTIVE:
  - Pulse frame_abort and clear counters.
  - If capture_en=1: remain ACTIVE and also pulse frame_start.
  - Otherwise go to WAIT_VS.
  - Any px_stb in that same cycle is dropped.
- Pulse rules: frame_start, frame_done and frame_abort are never high for more than one cycle. wr_en is never high outside ACTIVE, except for the final kept pixel, which is registered in the same cycle ACTIVE→DONE occurs.
- Mid-operation reset: all outputs return to reset values on the next edge. Any partial frame is discarded; there is no frame_done or frame_abort pulse.
- len_err clears only on reset.

Test Plan:
- Reset, then vsync rise with capture_en=1, then 480 lines of 640 pixels at defaults → frame_start once; exactly 307200 wr_en pulses; wr_data equals the input sequence; frame_done once after the last write; len_err=0.
- Crop X_START=8, Y_START=2, OUT_W=4, OUT_H=3, IN_W=16, IN_H=8, pixel value = y*16+x → 12 writes with values 0x28..0x2B, 0x38..0x3B, 0x48..0x4B; frame_done after line y=4 ends.
- capture_en=0 at vsync edge, full frame supplied → no wr_en, frame_start or frame_done.
- Second vsync edge after 100 lines, capture_en=1 → frame_abort and frame_start in the same cycle; counters restart; the next full frame produces 307200 writes.
- Line with 642 pixels (IN_W=640) → len_err=1 from the 641st pixel onward; 640 writes for that line; len_err stays set after subsequent frames.
- rst_n low for 1 cycle mid-line → all outputs 0 next cycle; state WAIT_VS; no writes until the next vsync edge.
